// File: rtl/uart_cmd_responder.sv
// -----------------------------------------------------------------------------
// uart_cmd_responder
//   Board-side end of the PC<->FPGA serial sensor protocol. Collects a 2-byte
//   request {command, address} from uart_rx and checks it. Valid requests start
//   a read handshake with the sensor controller. The block then sends a 2-byte
//   reply {response code, data} through uart_tx.
//
// Ports
//   i_Clock, i_Reset             clock, synchronous active-high reset
//   i_Rx_DV, i_Rx_Byte           received byte strobe / data from uart_rx
//   o_Tx_DV, o_Tx_Byte           transmit start strobe / byte to uart_tx
//   i_Tx_Done                    uart_tx finished the current byte
//   o_Sns_Req, o_Sns_Addr,       sensor read request, address, quantity
//   o_Sns_Sel
//   i_Sns_Ack, i_Sns_Err,        sensor response strobe, fault flag, data
//   i_Sns_Data
//   o_Busy                       FSM is not idle
//   o_Frame_Err                  inter-byte timeout, partial request dropped
//
// State     | meaning
// IDLE      | waiting for a command byte
// GET_ADDR  | command held, waiting for the address byte (timed)
// VALIDATE  | check command and address, choose an error reply or a sensor read
// SNS_REQ   | sensor request strobe is on the outputs
// SNS_WAIT  | waiting for the sensor ack (timed)
// TX_B0     | load reply byte 0 into uart_tx
// WAIT_B0   | waiting for uart_tx to finish byte 0
// TX_B1     | load reply byte 1 into uart_tx
// WAIT_B1   | waiting for uart_tx to finish byte 1
// -----------------------------------------------------------------------------
module uart_cmd_responder #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 100 * CLKS_PER_BIT,
  parameter int ADDR_MAX     = 31
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Done,
  output logic       o_Sns_Req,
  output logic [4:0] o_Sns_Addr,
  output logic [1:0] o_Sns_Sel,
  input  logic       i_Sns_Ack,
  input  logic       i_Sns_Err,
  input  logic [7:0] i_Sns_Data,
  output logic       o_Busy,
  output logic       o_Frame_Err
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_GET_ADDR = 4'd1;
  localparam logic [3:0] S_VALIDATE = 4'd2;
  localparam logic [3:0] S_SNS_REQ  = 4'd3;
  localparam logic [3:0] S_SNS_WAIT = 4'd4;
  localparam logic [3:0] S_TX_B0    = 4'd5;
  localparam logic [3:0] S_WAIT_B0  = 4'd6;
  localparam logic [3:0] S_TX_B1    = 4'd7;
  localparam logic [3:0] S_WAIT_B1  = 4'd8;

  localparam int              TMR_W    = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);
  localparam logic [TMR_W-1:0] TMR_SAT  = TMR_W'(TIMEOUT_CLKS);
  localparam logic [7:0]      ADDR_LIM = 8'(ADDR_MAX);

  localparam logic [7:0] RC_SNS_FAIL = 8'h1F;
  localparam logic [7:0] RC_BAD_CMD  = 8'hFE;
  localparam logic [7:0] RC_BAD_ADDR = 8'hFD;

  logic [3:0]       state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       b0_q, b0_d;
  logic [7:0]       b1_q, b1_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             tx_dv_q, tx_dv_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             sns_req_q, sns_req_d;
  logic [4:0]       sns_addr_q, sns_addr_d;
  logic [1:0]       sns_sel_q, sns_sel_d;
  logic             frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    // Free-running saturating timer; only GET_ADDR and SNS_WAIT look at it.
    timer_d     = (timer_q == TMR_SAT) ? timer_q : timer_q + 1'b1;
    tx_dv_d     = 1'b0;
    tx_byte_d   = tx_byte_q;
    sns_req_d   = 1'b0;
    sns_addr_d  = sns_addr_q;
    sns_sel_d   = sns_sel_q;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_Rx_DV) begin
          cmd_d   = i_Rx_Byte;
          timer_d = '0;
          state_d = S_GET_ADDR;
        end
      end
      S_GET_ADDR: begin
        // A byte arriving on the timeout cycle still counts.
        if (i_Rx_DV) begin
          addr_d  = i_Rx_Byte;
          state_d = S_VALIDATE;
        end else if (timer_q == TMR_LAST) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_VALIDATE: begin
        if (cmd_q > 8'h02) begin
          b0_d    = RC_BAD_CMD;
          b1_d    = cmd_q;
          state_d = S_TX_B0;
        end else if (addr_q > ADDR_LIM) begin
          b0_d    = RC_BAD_ADDR;
          b1_d    = addr_q;
          state_d = S_TX_B0;
        end else begin
          // Request outputs are registered so they line up with SNS_REQ.
          sns_req_d  = 1'b1;
          sns_addr_d = addr_q[4:0];
          sns_sel_d  = cmd_q[1:0];
          state_d    = S_SNS_REQ;
        end
      end
      S_SNS_REQ: begin
        timer_d = '0;
        state_d = S_SNS_WAIT;
      end
      S_SNS_WAIT: begin
        if (i_Sns_Ack) begin
          b0_d    = i_Sns_Err ? RC_SNS_FAIL : cmd_q;
          b1_d    = i_Sns_Err ? addr_q : i_Sns_Data;
          state_d = S_TX_B0;
        end else if (timer_q == TMR_LAST) begin
          b0_d    = RC_SNS_FAIL;
          b1_d    = addr_q;
          state_d = S_TX_B0;
        end
      end
      S_TX_B0: begin
        tx_dv_d   = 1'b1;
        tx_byte_d = b0_q;
        state_d   = S_WAIT_B0;
      end
      S_WAIT_B0: begin
        if (i_Tx_Done) state_d = S_TX_B1;
      end
      S_TX_B1: begin
        tx_dv_d   = 1'b1;
        tx_byte_d = b1_q;
        state_d   = S_WAIT_B1;
      end
      S_WAIT_B1: begin
        if (i_Tx_Done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      timer_q     <= '0;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= '0;
      sns_req_q   <= 1'b0;
      sns_addr_q  <= '0;
      sns_sel_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      timer_q     <= timer_d;
      tx_dv_q     <= tx_dv_d;
      tx_byte_q   <= tx_byte_d;
      sns_req_q   <= sns_req_d;
      sns_addr_q  <= sns_addr_d;
      sns_sel_q   <= sns_sel_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_Tx_DV     = tx_dv_q;
  assign o_Tx_Byte   = tx_byte_q;
  assign o_Sns_Req   = sns_req_q;
  assign o_Sns_Addr  = sns_addr_q;
  assign o_Sns_Sel   = sns_sel_q;
  assign o_Frame_Err = frame_err_q;
  assign o_Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder. The timeout is shortened so that the bench can
// exercise timeout boundaries in a few thousand cycles.
module tb_uart_cmd_responder;
  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_done = 1'b0;
  logic       sns_req;
  logic [4:0] sns_addr;
  logic [1:0] sns_sel;
  logic       sns_ack = 1'b0;
  logic       sns_err = 1'b0;
  logic [7:0] sns_data = 8'h00;
  logic       busy;
  logic       frame_err;

  int total = 0;
  int bad   = 0;

  uart_cmd_responder #(.CLKS_PER_BIT(2), .TIMEOUT_CLKS(TO), .ADDR_MAX(31)) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Rx_DV    (rx_dv),
    .i_Rx_Byte  (rx_byte),
    .o_Tx_DV    (tx_dv),
    .o_Tx_Byte  (tx_byte),
    .i_Tx_Done  (tx_done),
    .o_Sns_Req  (sns_req),
    .o_Sns_Addr (sns_addr),
    .o_Sns_Sel  (sns_sel),
    .i_Sns_Ack  (sns_ack),
    .i_Sns_Err  (sns_err),
    .i_Sns_Data (sns_data),
    .o_Busy     (busy),
    .o_Frame_Err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] addr;
    int         gap;
    int         mode;   // 0 no ack, 1 ack ok, 2 ack with fault
    int         dly;    // cycles from request strobe to ack
    logic [7:0] data;
    logic [7:0] b0;
    logic [7:0] b1;
    logic       req;
  } vec_t;

  vec_t tbl[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reply rules: bad command beats bad address; otherwise an ack counts only if
  // it arrives no later than the timeout cycle.
  task automatic model(input logic [7:0] cmd, input logic [7:0] addr, input int mode,
                       input int dly, input logic [7:0] data,
                       output logic [7:0] b0, output logic [7:0] b1, output logic req);
    if (cmd > 8'd2) begin
      b0 = 8'hFE; b1 = cmd; req = 1'b0;
    end else if (addr > 8'd31) begin
      b0 = 8'hFD; b1 = addr; req = 1'b0;
    end else begin
      req = 1'b1;
      if (mode != 0 && dly <= TO) begin
        b0 = (mode == 2) ? 8'h1F : cmd;
        b1 = (mode == 2) ? addr : data;
      end else begin
        b0 = 8'h1F; b1 = addr;
      end
    end
  endtask

  // Cycle (counted from the sample after the address byte) of the first Tx strobe.
  function automatic int lat(input logic [7:0] cmd, input logic [7:0] addr, input int mode, input int dly);
    if (cmd > 8'd2 || addr > 8'd31) return 2;
    if (mode != 0 && dly <= TO) return 3 + dly;
    return 3 + TO;
  endfunction

  task automatic run_txn(input string tag, input logic [7:0] cmd, input logic [7:0] addr,
                         input int gap, input int mode, input int dly, input logic [7:0] data,
                         input logic stray, input logic [7:0] e_b0, input logic [7:0] e_b1,
                         input logic e_req);
    int nreq, ntx, nfe, req_cyc, ack_at, done_at, dv1, dv2, e_dv;
    logic [7:0] got0, got1;
    logic [4:0] gaddr;
    logic [1:0] gsel;
    logic fin, stray_now;
    logic [7:0] ca;
    nreq = 0; ntx = 0; nfe = 0; req_cyc = -10; ack_at = -1; done_at = -10;
    dv1 = -1; dv2 = -1; got0 = 8'h00; got1 = 8'h00; gaddr = '0; gsel = '0; fin = 1'b0;
    e_dv = lat(cmd, addr, mode, dly);
    rx_dv = 1'b1; rx_byte = cmd; tick(); rx_dv = 1'b0;
    repeat (gap) tick();
    rx_dv = 1'b1; rx_byte = addr; tick(); rx_dv = 1'b0;
    for (int cyc = 0; cyc < 2 * TO + 40; cyc++) begin
      if (sns_req) begin
        nreq++; req_cyc = cyc; gaddr = sns_addr; gsel = sns_sel;
        if (mode != 0) ack_at = cyc + dly;
      end
      if (frame_err) nfe++;
      if (tx_dv) begin
        if (ntx == 0) begin got0 = tx_byte; dv1 = cyc; end
        else if (ntx == 1) begin got1 = tx_byte; dv2 = cyc; end
        ntx++;
        done_at = cyc + 3;
      end
      if (ntx >= 2 && cyc == done_at + 1) begin
        fin = 1'b1;
        break;
      end
      stray_now = stray && (nreq == 1) && (cyc == req_cyc + 1);
      sns_ack  = (cyc == ack_at);
      sns_err  = (mode == 2);
      sns_data = (cyc == ack_at) ? data : 8'($urandom);
      rx_dv    = stray_now;
      rx_byte  = 8'h00;
      tx_done  = (cyc == done_at) || stray_now;
      tick();
    end
    sns_ack = 1'b0; sns_err = 1'b0; rx_dv = 1'b0; tx_done = 1'b0;
    ca = cmd;
    chk({tag, " finished"}, fin, 1'b1);
    chk({tag, " req count"}, nreq, e_req ? 1 : 0);
    if (e_req) begin
      chk({tag, " sns addr"}, gaddr, addr[4:0]);
      chk({tag, " sns sel"}, gsel, ca[1:0]);
    end
    chk({tag, " tx byte0"}, got0, e_b0);
    chk({tag, " tx byte1"}, got1, e_b1);
    chk({tag, " tx count"}, ntx, 2);
    chk({tag, " dv0 cycle"}, dv1, e_dv);
    chk({tag, " dv1 cycle"}, dv2, e_dv + 5);
    chk({tag, " frame err"}, nfe, 0);
    chk({tag, " busy end"}, busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b0, b1, c, a, d;
    logic r;
    int cnt, fe_cyc, ntx, m, dl, g;

    tbl[0]  = '{8'h01, 8'h05, 3,      1, 4,      8'h1A, 8'h01, 8'h1A, 1'b1};
    tbl[1]  = '{8'h07, 8'h03, 2,      0, 0,      8'h00, 8'hFE, 8'h07, 1'b0};
    tbl[2]  = '{8'h02, 8'h20, 1,      0, 0,      8'h00, 8'hFD, 8'h20, 1'b0};
    tbl[3]  = '{8'h02, 8'h1F, 1,      1, 2,      8'h5C, 8'h02, 8'h5C, 1'b1};
    tbl[4]  = '{8'h00, 8'h02, 1,      0, 0,      8'h00, 8'h1F, 8'h02, 1'b1};
    tbl[5]  = '{8'h00, 8'h02, 1,      2, 7,      8'h33, 8'h1F, 8'h02, 1'b1};
    tbl[6]  = '{8'h00, 8'h00, 0,      1, 1,      8'hA5, 8'h00, 8'hA5, 1'b1};
    tbl[7]  = '{8'h01, 8'h07, TO - 1, 1, TO,     8'h44, 8'h01, 8'h44, 1'b1};
    tbl[8]  = '{8'h02, 8'h09, 2,      1, TO + 1, 8'h77, 8'h1F, 8'h09, 1'b1};
    tbl[9]  = '{8'hFF, 8'hFF, 1,      0, 0,      8'h00, 8'hFE, 8'hFF, 1'b0};
    tbl[10] = '{8'h03, 8'h00, 1,      0, 0,      8'h00, 8'hFE, 8'h03, 1'b0};

    rst = 1'b1; tick(); tick();
    chk("reset outputs", {tx_dv, tx_byte, sns_req, sns_addr, sns_sel, busy, frame_err}, '0);
    rst = 1'b0; tick();

    for (int i = 0; i < 11; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].addr, tbl[i].gap, tbl[i].mode,
              tbl[i].dly, tbl[i].data, 1'b0, tbl[i].b0, tbl[i].b1, tbl[i].req);

    // Inter-byte timeout: one frame error exactly TO cycles after the command.
    rx_dv = 1'b1; rx_byte = 8'h00; tick(); rx_dv = 1'b0;
    cnt = 0; fe_cyc = -1; ntx = 0;
    for (int i = 0; i <= 2 * TO; i++) begin
      if (frame_err) begin cnt++; fe_cyc = i; end
      if (tx_dv) ntx++;
      tick();
    end
    chk("frame err count", cnt, 1);
    chk("frame err cycle", fe_cyc, TO);
    chk("frame err no tx", ntx, 0);
    chk("frame err idle", busy, 1'b0);
    run_txn("after frame err", 8'h00, 8'h00, 1, 1, 3, 8'h5A, 1'b0, 8'h00, 8'h5A, 1'b1);

    // Reset while waiting on uart_tx for byte 0.
    rx_dv = 1'b1; rx_byte = 8'h01; tick();
    rx_byte = 8'h05; tick(); rx_dv = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10 && !sns_req; i++) tick();
    chk("pre-reset req", sns_req, 1'b1);
    tick();
    sns_ack = 1'b1; sns_data = 8'h1A; tick(); sns_ack = 1'b0;
    for (int i = 0; i < 10 && !tx_dv; i++) tick();
    chk("pre-reset tx dv", tx_dv, 1'b1);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid reset outputs", {tx_dv, tx_byte, sns_req, sns_addr, sns_sel, busy, frame_err}, '0);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    ntx = 0;
    for (int i = 0; i < 5; i++) begin
      if (tx_dv || busy) ntx++;
      tick();
    end
    chk("stray done ignored", ntx, 0);
    run_txn("stray in wait", 8'h02, 8'h03, 1, 1, 5, 8'h6E, 1'b1, 8'h02, 8'h6E, 1'b1);

    // Random requests against the reply rules.
    for (int n = 0; n < 30; n++) begin
      m = $urandom_range(0, 3);
      c = (m < 3) ? 8'(m) : 8'($urandom);
      a = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 40)) : 8'($urandom);
      m = $urandom_range(0, 2);
      dl = $urandom_range(1, TO + 3);
      g = $urandom_range(0, TO - 1);
      d = 8'($urandom);
      model(c, a, m, dl, d, b0, b1, r);
      run_txn($sformatf("rnd%0d", n), c, a, g, m, dl, d, 1'b0, b0, b1, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
